// File: rtl/mem_byte_if.sv
// Request/array bus of the byte-serial memory controller.
// The master side is the MAR/MDR datapath together with the 512x8 byte array.
interface mem_byte_if;
    logic        MOV;
    logic        RW;
    logic        IFetch;
    logic [5:0]  opcode;
    logic [31:0] Address;
    logic [31:0] DataIn;
    logic [31:0] DataOut;
    logic        MOC;
    logic        AdrErr;
    logic [8:0]  ByteAddr;
    logic [7:0]  ByteWr;
    logic        ByteWE;
    logic [7:0]  ByteRd;

    modport master (
        output MOV, RW, IFetch, opcode, Address, DataIn, ByteRd,
        input  DataOut, MOC, AdrErr, ByteAddr, ByteWr, ByteWE
    );

    modport slave (
        input  MOV, RW, IFetch, opcode, Address, DataIn, ByteRd,
        output DataOut, MOC, AdrErr, ByteAddr, ByteWr, ByteWE
    );
endinterface

// File: rtl/mem_byte_ctrl.sv
// Breaks a MOV/MOC word, halfword or byte request into big-endian single-byte
// accesses of a 512x8 array, one per clock, with sign/zero-extended loads.
module mem_byte_ctrl (
    input  logic        Clk,
    input  logic        Clr,
    mem_byte_if.slave   bus
);
    typedef enum logic [1:0] {IDLE = 2'd0, XFER = 2'd1, DONE = 2'd2} state_t;

    state_t      state_r, state_s;
    logic [8:0]  base_r, base_s;
    logic [31:0] data_r, data_s;
    logic        rw_r, rw_s;
    logic        sign_r, sign_s;
    logic [1:0]  last_r, last_s;
    logic [1:0]  beat_r, beat_s;
    logic [23:0] asm_r, asm_s;
    logic [31:0] dout_r, dout_s;
    logic        moc_r, moc_s;
    logic        err_r, err_s;
    logic        we_r, we_s;
    logic [8:0]  addr_r, addr_s;
    logic [7:0]  wr_r, wr_s;

    logic [1:0]  req_last_s;
    logic        req_sign_s;
    logic        req_rw_s;
    logic        req_misaligned_s;
    logic [31:0] shifted_s;
    logic        unused_addr_s;

    assign unused_addr_s = ^bus.Address[31:9];

    // Byte idx of a word, idx 3 being the most significant byte.
    function automatic logic [7:0] pick_byte(input logic [31:0] word, input logic [1:0] idx);
        case (idx)
            2'd0:    pick_byte = word[7:0];
            2'd1:    pick_byte = word[15:8];
            2'd2:    pick_byte = word[23:16];
            default: pick_byte = word[31:24];
        endcase
    endfunction

    function automatic logic [31:0] extend_load(input logic [31:0] raw, input logic [1:0] last,
                                                input logic sign);
        case (last)
            2'd0:    extend_load = {{24{sign & raw[7]}}, raw[7:0]};
            2'd1:    extend_load = {{16{sign & raw[15]}}, raw[15:0]};
            default: extend_load = raw;
        endcase
    endfunction

    // Request decode: last = beats-1, fetch overrides direction and size.
    always_comb begin
        req_last_s = 2'd3;
        req_sign_s = 1'b0;
        req_rw_s   = bus.RW;
        if (bus.IFetch) begin
            req_rw_s = 1'b1;
        end else begin
            case (bus.opcode)
                6'h20:               begin req_last_s = 2'd0; req_sign_s = 1'b1; end
                6'h24, 6'h28:        begin req_last_s = 2'd0; req_sign_s = 1'b0; end
                6'h21:               begin req_last_s = 2'd1; req_sign_s = 1'b1; end
                6'h25, 6'h29:        begin req_last_s = 2'd1; req_sign_s = 1'b0; end
                default:             begin req_last_s = 2'd3; req_sign_s = 1'b0; end
            endcase
        end
        case (req_last_s)
            2'd1:    req_misaligned_s = bus.Address[0];
            2'd3:    req_misaligned_s = |bus.Address[1:0];
            default: req_misaligned_s = 1'b0;
        endcase
    end

    // Next-state and next-output logic; outputs are registered one edge ahead.
    always_comb begin
        state_s   = state_r;
        base_s    = base_r;
        data_s    = data_r;
        rw_s      = rw_r;
        sign_s    = sign_r;
        last_s    = last_r;
        beat_s    = beat_r;
        asm_s     = asm_r;
        dout_s    = dout_r;
        moc_s     = moc_r;
        err_s     = err_r;
        we_s      = we_r;
        addr_s    = addr_r;
        wr_s      = wr_r;
        shifted_s = {asm_r, bus.ByteRd};
        case (state_r)
            IDLE: begin
                if (bus.MOV) begin
                    base_s = bus.Address[8:0];
                    data_s = bus.DataIn;
                    rw_s   = req_rw_s;
                    sign_s = req_sign_s;
                    last_s = req_last_s;
                    beat_s = 2'd0;
                    asm_s  = 24'd0;
                    addr_s = bus.Address[8:0];
                    if (req_misaligned_s) begin
                        state_s = DONE;
                        moc_s   = 1'b1;
                        err_s   = 1'b1;
                        we_s    = 1'b0;
                    end else begin
                        state_s = XFER;
                        err_s   = 1'b0;
                        we_s    = ~req_rw_s;
                        wr_s    = pick_byte(bus.DataIn, req_last_s);
                    end
                end else begin
                    state_s = IDLE;
                    addr_s  = base_r;
                end
            end
            XFER: begin
                if (rw_r) begin
                    asm_s = shifted_s[23:0];
                end else begin
                    asm_s = asm_r;
                end
                if (beat_r == last_r) begin
                    state_s = DONE;
                    moc_s   = 1'b1;
                    err_s   = 1'b0;
                    we_s    = 1'b0;
                    addr_s  = base_r;
                    if (rw_r) begin
                        dout_s = extend_load(shifted_s, last_r, sign_r);
                    end else begin
                        dout_s = dout_r;
                    end
                end else begin
                    beat_s = beat_r + 2'd1;
                    addr_s = base_r + {7'd0, beat_s};
                    wr_s   = pick_byte(data_r, last_r - beat_r - 2'd1);
                    we_s   = ~rw_r;
                end
            end
            DONE: begin
                // MOV must be seen low before another request can be accepted.
                if (!bus.MOV) begin
                    state_s = IDLE;
                    moc_s   = 1'b0;
                    err_s   = 1'b0;
                end else begin
                    state_s = DONE;
                end
            end
            default: begin
                state_s = IDLE;
                moc_s   = 1'b0;
                err_s   = 1'b0;
                we_s    = 1'b0;
            end
        endcase
    end

    // State and output registers.
    always_ff @(posedge Clk or negedge Clr) begin
        if (!Clr) begin
            state_r <= IDLE;
            base_r  <= 9'd0;
            data_r  <= 32'd0;
            rw_r    <= 1'b0;
            sign_r  <= 1'b0;
            last_r  <= 2'd0;
            beat_r  <= 2'd0;
            asm_r   <= 24'd0;
            dout_r  <= 32'd0;
            moc_r   <= 1'b0;
            err_r   <= 1'b0;
            we_r    <= 1'b0;
            addr_r  <= 9'd0;
            wr_r    <= 8'd0;
        end else begin
            state_r <= state_s;
            base_r  <= base_s;
            data_r  <= data_s;
            rw_r    <= rw_s;
            sign_r  <= sign_s;
            last_r  <= last_s;
            beat_r  <= beat_s;
            asm_r   <= asm_s;
            dout_r  <= dout_s;
            moc_r   <= moc_s;
            err_r   <= err_s;
            we_r    <= we_s;
            addr_r  <= addr_s;
            wr_r    <= wr_s;
        end
    end

    assign bus.DataOut  = dout_r;
    assign bus.MOC      = moc_r;
    assign bus.AdrErr   = err_r;
    assign bus.ByteAddr = addr_r;
    assign bus.ByteWr   = wr_r;
    assign bus.ByteWE   = we_r;
endmodule
